// File: rtl/seq_ctrl_pkg.sv
// Shared state type and sizing helper for the serial-pattern detection controller.
package seq_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } seq_state_e;

   // Width able to hold a pattern length of 1..pat_w inclusive.
   function automatic int len_w(input int pat_w);
      return $clog2(pat_w) + 1;
   endfunction

endpackage

// File: rtl/seq_match_core.sv
// Serial history shift register with fill counter and length-masked pattern compare.
// hit_o is combinational and reflects the bit being shifted in this cycle.
module seq_match_core
   import seq_ctrl_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int LEN_W = len_w(PAT_W)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear_i,
   input  logic             shift_i,
   input  logic             bit_i,
   input  logic             overlap_i,
   input  logic [LEN_W-1:0] len_i,
   input  logic [PAT_W-1:0] pattern_i,
   output logic             hit_o
);

   logic [PAT_W-1:0] hist_q, hist_d, mask;
   logic [LEN_W-1:0] fill_q, fill_d, fill_inc;

   assign hist_d   = {hist_q[PAT_W-2:0], bit_i};
   assign fill_inc = (fill_q >= len_i) ? len_i : fill_q + LEN_W'(1);

   for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
      assign mask[gi] = (LEN_W'(gi) < len_i);
   end

   assign hit_o  = shift_i && (fill_inc >= len_i) && (((hist_d ^ pattern_i) & mask) == '0);
   // Without overlap a match consumes the window, so the next one needs len fresh bits.
   assign fill_d = (hit_o && !overlap_i) ? '0 : fill_inc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (clear_i) begin
         hist_q <= '0;
         fill_q <= '0;
      end else if (shift_i) begin
         hist_q <= hist_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detection controller: config port, start/abort run FSM,
// match counting. Optional run timeout is enabled by defining SEQ_CTRL_TIMEOUT_EN.
module seq_detect_ctrl
   import seq_ctrl_pkg::*;
#(
   parameter int PAT_W  = 8,
   parameter int CNT_W  = 8,
   parameter int TO_CYC = 256
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [PAT_W-1:0]         cfg_pattern,
   input  logic [len_w(PAT_W)-1:0]  cfg_len,
   input  logic [CNT_W-1:0]         cfg_target,
   input  logic                     cfg_overlap,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     a,
   input  logic                     a_valid,
   output logic                     match,
   output logic [CNT_W-1:0]         match_cnt,
   output logic                     busy,
   output logic                     done,
   output logic                     timeout
);

   localparam int               LEN_W   = len_w(PAT_W);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

   seq_state_e       state_q;
   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] target_q, cnt_q, cnt_d;
   logic             overlap_q, match_q, done_q, hit;

`ifdef SEQ_CTRL_TIMEOUT_EN
   localparam int              TO_W    = $clog2(TO_CYC);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
   logic [TO_W-1:0] to_cnt_q;
   logic            timeout_q;
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign len_d     = (cfg_len == '0 || cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
   assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   assign cfg_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign match     = match_q;
   assign done      = done_q;
   assign match_cnt = cnt_q;

   seq_match_core #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (state_q == ARM),
      .shift_i   ((state_q == RUN) && a_valid),
      .bit_i     (a),
      .overlap_i (overlap_q),
      .len_i     (len_q),
      .pattern_i (pat_q),
      .hit_o     (hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pat_q     <= '0;
         len_q     <= LEN_MAX;
         target_q  <= '0;
         overlap_q <= 1'b0;
         cnt_q     <= '0;
         match_q   <= 1'b0;
         done_q    <= 1'b0;
`ifdef SEQ_CTRL_TIMEOUT_EN
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         match_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cfg_valid) begin
                  pat_q     <= cfg_pattern;
                  len_q     <= len_d;
                  target_q  <= cfg_target;
                  overlap_q <= cfg_overlap;
               end
               if (start) state_q <= ARM;
            end
            ARM: begin
               if (abort) begin
                  state_q <= IDLE;
               end else begin
                  cnt_q   <= '0;
                  state_q <= RUN;
`ifdef SEQ_CTRL_TIMEOUT_EN
                  to_cnt_q  <= '0;
                  timeout_q <= 1'b0;
`endif
               end
            end
            RUN: begin
               // Abort suppresses a same-cycle match entirely.
               if (abort) begin
                  state_q <= IDLE;
               end else if (hit) begin
                  match_q <= 1'b1;
                  cnt_q   <= cnt_d;
`ifdef SEQ_CTRL_TIMEOUT_EN
                  to_cnt_q <= '0;
`endif
                  if (target_q != '0 && cnt_d == target_q) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end
               end
`ifdef SEQ_CTRL_TIMEOUT_EN
               else if (to_cnt_q == TO_LAST) begin
                  state_q   <= DONE;
                  done_q    <= 1'b1;
                  timeout_q <= 1'b1;
               end else begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
               end
`endif
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed plan cases plus randomized runs
// checked against a queue-based reference of the detection rules.
module tb_seq_detect_ctrl;

   localparam int PAT_W  = 8;
   localparam int CNT_W  = 8;
   localparam int TO_CYC = 16;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             cfg_valid = 1'b0;
   logic             cfg_ready;
   logic [PAT_W-1:0] cfg_pattern = '0;
   logic [3:0]       cfg_len = '0;
   logic [CNT_W-1:0] cfg_target = '0;
   logic             cfg_overlap = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             a = 1'b0;
   logic             a_valid = 1'b0;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             busy;
   logic             done;
   logic             timeout;

   seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .TO_CYC(TO_CYC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_target  (cfg_target),
      .cfg_overlap (cfg_overlap),
      .start       (start),
      .abort       (abort),
      .a           (a),
      .a_valid     (a_valid),
      .match       (match),
      .match_cnt   (match_cnt),
      .busy        (busy),
      .done        (done),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int last_cnt = 0;
   bit to_flag = 1'b0;
   bit q_a[$];
   bit q_v[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_bits(input logic [63:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         q_a.push_back(bits[i]);
         q_v.push_back(1'b1);
      end
   endtask

   task automatic drive_cfg(input logic [7:0] pat, input logic [3:0] len_in,
                            input logic [7:0] tgt, input bit ovl);
      cfg_valid   = 1'b1;
      cfg_pattern = pat;
      cfg_len     = len_in;
      cfg_target  = tgt;
      cfg_overlap = ovl;
   endtask

   task automatic scramble_cfg();
      cfg_pattern = 8'($urandom);
      cfg_len     = 4'($urandom);
      cfg_target  = 8'($urandom);
      cfg_overlap = 1'($urandom);
   endtask

   // One full run: config (optional), start, stream q_a/q_v, end by done, abort or final abort.
   task automatic run(input string name, input logic [7:0] pat, input logic [3:0] len_in,
                      input logic [7:0] tgt, input bit ovl, input bit do_cfg, input bit sep,
                      input int abort_at);
      int  eff_len, cnt, idle;
      bit  hist[$];
      bit  ended, exp_m, exp_d, exp_t, ab, hitm;
      eff_len = (len_in == 0 || len_in > 8) ? 8 : int'(len_in);
      chk({name, "_idle_ready"}, 32'(cfg_ready), 32'd1);
      if (do_cfg && sep) begin
         drive_cfg(pat, len_in, tgt, ovl);
         tick();
         cfg_valid = 1'b0;
         scramble_cfg();
         chk({name, "_cfg_busy"}, 32'(busy), 32'd0);
      end
      if (do_cfg && !sep) drive_cfg(pat, len_in, tgt, ovl);
      start   = 1'b1;
      a_valid = 1'b1;
      a       = 1'($urandom);
      tick();
      start     = 1'b0;
      cfg_valid = 1'b0;
      scramble_cfg();
      a_valid = 1'b1;
      a       = 1'($urandom);
      chk({name, "_arm_busy"}, 32'(busy), 32'd1);
      chk({name, "_arm_ready"}, 32'(cfg_ready), 32'd0);
      chk({name, "_arm_match"}, 32'(match), 32'd0);
      chk({name, "_arm_cnt"}, 32'(match_cnt), 32'(last_cnt));
      tick();
      to_flag = 1'b0;
      chk({name, "_run_cnt0"}, 32'(match_cnt), 32'd0);
      chk({name, "_run_to0"}, 32'(timeout), 32'd0);
      chk({name, "_run_ready"}, 32'(cfg_ready), 32'd0);
      cnt = 0;
      idle = 0;
      ended = 1'b0;
      for (int i = 0; i < q_a.size() && !ended; i++) begin
         a         = q_a[i];
         a_valid   = q_v[i];
         ab        = (i == abort_at);
         abort     = ab;
         start     = ($urandom_range(0, 7) == 0);
         cfg_valid = 1'($urandom);
         exp_m = 1'b0;
         exp_d = 1'b0;
         exp_t = 1'b0;
         if (!ab) begin
            if (q_v[i]) begin
               hist.push_back(q_a[i]);
               if (hist.size() > 8) void'(hist.pop_front());
               if (hist.size() >= eff_len) begin
                  hitm = 1'b1;
                  for (int j = 0; j < eff_len; j++)
                     if (hist[hist.size() - 1 - j] != pat[j]) hitm = 1'b0;
                  exp_m = hitm;
               end
            end
            if (exp_m) begin
               if (cnt < 255) cnt++;
               idle = 0;
               if (!ovl) hist.delete();
               if (tgt != 0 && cnt == int'(tgt)) exp_d = 1'b1;
            end
`ifdef SEQ_CTRL_TIMEOUT_EN
            else if (idle == TO_CYC - 1) begin
               exp_d = 1'b1;
               exp_t = 1'b1;
            end else begin
               idle++;
            end
`endif
         end
         tick();
         abort     = 1'b0;
         start     = 1'b0;
         cfg_valid = 1'b0;
         if (exp_t) to_flag = 1'b1;
         chk({name, "_match"}, 32'(match), 32'(exp_m));
         chk({name, "_cnt"}, 32'(match_cnt), 32'(cnt));
         chk({name, "_done"}, 32'(done), 32'(exp_d));
         chk({name, "_busy"}, 32'(busy), 32'(!ab));
         chk({name, "_timeout"}, 32'(timeout), 32'(to_flag));
         if (ab) begin
            ended = 1'b1;
         end else if (exp_d) begin
            tick();
            chk({name, "_end_busy"}, 32'(busy), 32'd0);
            chk({name, "_end_done"}, 32'(done), 32'd0);
            chk({name, "_end_ready"}, 32'(cfg_ready), 32'd1);
            chk({name, "_end_cnt"}, 32'(match_cnt), 32'(cnt));
            ended = 1'b1;
         end
      end
      if (!ended) begin
         abort = 1'b1;
         tick();
         abort = 1'b0;
         chk({name, "_abt_busy"}, 32'(busy), 32'd0);
         chk({name, "_abt_done"}, 32'(done), 32'd0);
         chk({name, "_abt_cnt"}, 32'(match_cnt), 32'(cnt));
      end
      a_valid  = 1'b0;
      last_cnt = cnt;
      q_a.delete();
      q_v.delete();
      $display("run %s: pat=%02h len=%0d tgt=%0d ovl=%0d matches=%0d timeout=%0d",
               name, pat, len_in, tgt, ovl, cnt, to_flag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, ab_at;
      logic [3:0] rl;

      repeat (2) tick();
      chk("rst_ready", 32'(cfg_ready), 32'd1);
      chk("rst_match", 32'(match), 32'd0);
      chk("rst_cnt", 32'(match_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      rst_n = 1'b1;
      tick();

      push_bits(64'b01110001, 8);
      run("plan1", 8'b01110001, 4'd8, 8'd1, 1'b0, 1'b1, 1'b0, -1);
      chk("plan1_total", 32'(match_cnt), 32'd1);

      push_bits(64'b10101, 5);
      run("plan2_ovl", 8'b101, 4'd3, 8'd0, 1'b1, 1'b1, 1'b1, -1);
      chk("plan2_ovl_total", 32'(match_cnt), 32'd2);

      push_bits(64'b10101, 5);
      run("plan2_nov", 8'b101, 4'd3, 8'd0, 1'b0, 1'b1, 1'b0, -1);
      chk("plan2_nov_total", 32'(match_cnt), 32'd1);

      q_a = '{1'b1, 1'b0, 1'b1, 1'b1};
      q_v = '{1'b1, 1'b0, 1'b0, 1'b1};
      run("plan3_gap", 8'b11, 4'd2, 8'd0, 1'b0, 1'b1, 1'b1, -1);
      chk("plan3_total", 32'(match_cnt), 32'd1);

      push_bits(64'b101, 3);
      run("plan4_abort", 8'b101, 4'd3, 8'd0, 1'b0, 1'b1, 1'b0, 2);
      chk("plan4_total", 32'(match_cnt), 32'd0);

      push_bits(64'hA5, 8);
      run("plan5_len0", 8'hA5, 4'd0, 8'd1, 1'b0, 1'b1, 1'b0, -1);
      chk("plan5_total", 32'(match_cnt), 32'd1);

      push_bits(64'hFFFF_FFFF_FFFF_FFFF, 64);
      push_bits(64'hFFFF_FFFF_FFFF_FFFF, 64);
      push_bits(64'hFFFF_FFFF_FFFF_FFFF, 64);
      push_bits(64'hFFFF_FFFF_FFFF_FFFF, 64);
      push_bits(64'hF, 4);
      run("sat", 8'h01, 4'd1, 8'd0, 1'b0, 1'b1, 1'b0, -1);
      chk("sat_total", 32'(match_cnt), 32'd255);

`ifdef SEQ_CTRL_TIMEOUT_EN
      push_bits(64'h0, 20);
      run("plan6_to", 8'hFF, 4'd8, 8'd1, 1'b0, 1'b1, 1'b0, -1);
      chk("plan6_timeout", 32'(timeout), 32'd1);
      chk("plan6_total", 32'(match_cnt), 32'd0);
`endif

      for (int r = 0; r < 30; r++) begin
         rl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
         nb = $urandom_range(8, 40);
         ab_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb - 1) : -1;
         for (int i = 0; i < nb; i++) begin
            q_a.push_back(1'($urandom));
            q_v.push_back($urandom_range(0, 3) != 0);
         end
         run($sformatf("rnd%0d", r), 8'($urandom), rl, 8'($urandom_range(0, 4)),
             1'($urandom), 1'b1, 1'($urandom), ab_at);
      end

      // Asynchronous reset in the middle of a run.
      drive_cfg(8'h01, 4'd1, 8'd0, 1'b0);
      start   = 1'b1;
      a_valid = 1'b0;
      tick();
      cfg_valid = 1'b0;
      start     = 1'b0;
      tick();
      a       = 1'b1;
      a_valid = 1'b1;
      repeat (3) tick();
      chk("prerst_cnt", 32'(match_cnt), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_cnt", 32'(match_cnt), 32'd0);
      chk("midrst_ready", 32'(cfg_ready), 32'd1);
      chk("midrst_done", 32'(done), 32'd0);
      a_valid = 1'b0;
      tick();
      rst_n    = 1'b1;
      last_cnt = 0;
      tick();

      // Reset config must be pattern 0, len 8, target 0, no overlap.
      push_bits(64'h0, 17);
      run("dflt_cfg", 8'h00, 4'd8, 8'd0, 1'b0, 1'b0, 1'b0, -1);
      chk("dflt_total", 32'(match_cnt), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Programmable serial-pattern detection controller. Accepts a pattern, length, match target and overlap mode through a valid/ready config port, then runs a start/abort sequence over a qualified serial bit stream. It counts matches and ends the run after the target count. It sits between a control host and the serial input, replacing fixed-pattern detectors with one configurable, sequenced block.

## Interface
Parameters:
- PAT_W, 8, maximum pattern length in bits
- CNT_W, 8, match counter / target width
- TO_CYC, 256, timeout in clock cycles (used only with SEQ_CTRL_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accepted when high with cfg_valid
- cfg_pattern  in  PAT_W  pattern; bit [len-1] is oldest bit
- cfg_len  in  $clog2(PAT_W)+1  pattern length 1..PAT_W
- cfg_target  in  CNT_W  matches per run; 0 = continuous
- cfg_overlap  in  1  1 = overlapping matches allowed
- start  in  1  run request pulse
- abort  in  1  terminate run
- a  in  1  serial data bit
- a_valid  in  1  a is sampled when high
- match  out  1  one-cycle match pulse
- match_cnt  out  CNT_W  matches in current/last run
- busy  out  1  state != IDLE
- done  out  1  one-cycle run-complete pulse
- timeout  out  1  last run ended by timeout

## Operation
- States: IDLE, ARM, RUN, DONE.
- IDLE: cfg_ready=1; handshake latches all cfg_* fields. cfg_len of 0 or >PAT_W latches as PAT_W. start → ARM. start in other states is ignored.
- Same-cycle cfg handshake and start: new config applies to the run.
- ARM (1 cycle): clears history, fill count, match_cnt and timeout. Then → RUN.
- RUN: each a_valid bit shifts into history and increments fill count (saturates at len).
- Match when fill count ≥ len after the shift and the last len bits equal cfg_pattern[len-1:0].
- On match: match pulse; match_cnt increments, saturating at all-ones.
- On match with overlap=0: fill count resets to 0, so the next match needs len fresh bits.
- On match with overlap=1: history is kept.
- target≠0 and match_cnt reaches target → DONE. target=0 → RUN until abort or timeout.
- DONE (1 cycle): done=1, then → IDLE.
- abort in ARM/RUN/DONE → IDLE next edge, no done pulse, match_cnt holds. Abort has priority over a same-cycle match: no match pulse, no increment.
- Bits arriving while not in RUN are discarded.

## Timing
- Reset values: cfg_ready=1, match=0, match_cnt=0, busy=0, done=0, timeout=0, state=IDLE. Latched config resets to pattern 0, len PAT_W, target 0, overlap 0.
- Latency: completing bit sampled at edge k → match high for the cycle after edge k (registered, 1 cycle).
- Final target match at edge k → state=DONE after edge k; done high that same cycle as match; IDLE after edge k+1.
- start sampled at edge k → ARM after k, RUN after k+1. The first bit sampled is at edge k+2.
- Reset mid-run: immediate return to reset values; no done.

## Configuration
- SEQ_CTRL_TIMEOUT_EN defined:
  - A cycle counter runs in RUN and is cleared in ARM and on every match.
  - When it reaches TO_CYC-1 with no match that cycle → DONE with timeout=1.
  - timeout stays high until the next ARM.
  - abort wins over timeout.
- Not defined: no counter; timeout tied 0; the port remains.

## Structure
- Package seq_ctrl_pkg: state enum type (IDLE/ARM/RUN/DONE) and the length-width localparam function.
- Sub-module seq_match_core: history shift register, fill counter, masked compare. Inputs: clear, shift, overlap, len, pattern. Output: combinational hit.
- seq_detect_ctrl owns the FSM, config registers, counter and timeout.

## Test plan
- Pattern 8'b01110001, len 8, target 1; stream 0,1,1,1,0,0,0,1 → match and done in the cycle after the 8th bit; match_cnt=1; IDLE next.
- Pattern 3'b101, len 3, overlap=1, target 0; stream 1,0,1,0,1 → 2 matches (after bits 3 and 5). Same with overlap=0 → 1 match.
- a_valid gaps: pattern 2'b11 with a_valid low between the two 1s → one match, timed after the 2nd valid bit.
- abort asserted in the same cycle as the completing bit → no match, match_cnt unchanged, no done, IDLE next.
- cfg handshake + start in the same cycle, cfg_len=0 → pattern treated as PAT_W bits; cfg_ready low through ARM/RUN/DONE.
- With SEQ_CTRL_TIMEOUT_EN and TO_CYC=16: no matching input → DONE on the 16th RUN cycle with timeout=1, done=1, match_cnt=0.
